// File: rtl/serial_mag_comparator_if.sv
// Handshake and operand/result bundle for the bit-serial magnitude comparator.
// The master drives a request with operands; the slave returns status and result.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             Greater;
  logic             Equal;

  modport master (output start, A, B, input busy, done, Greater, Equal);
  modport slave  (input start, A, B, output busy, done, Greater, Equal);
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: scans both operands LSB-first, one bit per clock,
// and reports Greater/Equal with a one-cycle done strobe after WIDTH cycles.
module serial_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_mag_comparator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNTW-1:0]  count;
  logic             gt;
  logic             eq;
  logic             gt_next;
  logic             eq_next;
  logic             last_bit;

  // A differing bit at a higher position overrides whatever the lower bits decided.
  always_comb begin
    gt_next = gt;
    eq_next = eq;
    if (sa[0] != sb[0]) begin
      gt_next = sa[0];
      eq_next = 1'b0;
    end
  end

  assign last_bit = (count == CNTW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sa          <= '0;
      sb          <= '0;
      count       <= '0;
      gt          <= 1'b0;
      eq          <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.Greater <= 1'b0;
      bus.Equal   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            sa       <= bus.A;
            sb       <= bus.B;
            count    <= '0;
            gt       <= 1'b0;
            eq       <= 1'b1;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          gt    <= gt_next;
          eq    <= eq_next;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          count <= count + 1'b1;
          // The final bit is folded in directly so the result lands on the edge leaving RUN.
          if (last_bit) begin
            bus.Greater <= gt_next;
            bus.Equal   <= eq_next;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
